scsi_bus_strobe: RTL and testbench
==================================

Name: scsi_bus_strobe

Overview:
- Downstream timing stage for the SCSI state-machine output decode.
- Converts its level requests (SCSI_CS, DACK, RE, WE, SET_DSACK) into correctly sequenced chip-select, DMA-acknowledge and read/write strobes for the WD33C93.
- Provides setup, pulse, hold and recovery timing on those strobes.
- Returns a one-cycle DONE and RD_LATCH to the state machine and holds the CPU DSACK level.

Parameters:
SETUP_CYC, 1, cycles select is asserted before the strobe (legal 0..15; 0 skips SETUP)
STROBE_CYC, 3, cycles _IOR/_IOW is held low (legal 1..15)
RECOV_CYC, 2, idle cycles after an access before the next may start (legal 0..15; 0 skips RECOV)

Ports:
CLK45  in  1  system clock, all logic rising-edge
RST  in  1  reset, synchronous, active-high
SCSI_CS  in  1  CPU register-access request from SCSI state-machine decode, active-high
DACK  in  1  DMA-access request from decode, active-high
RE  in  1  access is a read, active-high
WE  in  1  access is a write, active-high
SET_DSACK  in  1  set DSACK level, active-high
CLR_DSACK  in  1  clear DSACK level (CPU cycle end), active-high
_CSS  out  1  WD33C93 chip select, active-low
_DACK  out  1  WD33C93 DMA acknowledge, active-low
_IOR  out  1  read strobe, active-low
_IOW  out  1  write strobe, active-low
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse in HOLD
RD_LATCH  out  1  one-cycle pulse on final STROBE cycle of a read
DSACK  out  1  registered DSACK level to CPU logic
ERR  out  1  one-cycle pulse on an illegal request

Behaviour:
- All outputs are registered.
- Reset values:
  - _CSS=_DACK=_IOR=_IOW=1.
  - BUSY=DONE=RD_LATCH=DSACK=ERR=0.
  - State IDLE, counter 0.
- RST mid-access: at the next edge, all strobes are deasserted and the state returns to IDLE; no DONE is issued.
- States: IDLE, SETUP, STROBE, HOLD, RECOV. Counter is 4-bit and loads N-1 on state entry; the state exits when the counter reaches 0.
- IDLE acceptance:
  - A request is sampled each edge in IDLE.
  - Legal request: (SCSI_CS|DACK) with exactly one of RE/WE set.
  - SCSI_CS and DACK together: SCSI_CS wins; DACK is ignored until it is re-sampled later.
  - RE and WE together, or neither with a select present: no access, ERR pulses for one cycle, state stays IDLE.
  - Select type (CS or DACK) and direction (RD or WR) are latched on acceptance. Input changes during an access are ignored.
- IDLE -> SETUP, or -> STROBE if SETUP_CYC=0. The selected line (_CSS or _DACK) goes low from this edge and stays low through HOLD.
- SETUP: SETUP_CYC cycles, select low, strobe high -> STROBE.
- STROBE: STROBE_CYC cycles with _IOR (read) or _IOW (write) low.
  - RD_LATCH=1 on the last STROBE cycle of a read only.
  - -> HOLD.
- HOLD: exactly 1 cycle.
  - Strobe high, select still low, DONE=1.
  - -> RECOV, or -> IDLE if RECOV_CYC=0.
- RECOV: RECOV_CYC cycles with all strobes high and BUSY=1 -> IDLE.
- Strobe exclusivity: _IOR and _IOW are never low together. _CSS and _DACK are never low together.
- Latency (defaults):
  - Request sampled at edge k.
  - Select low for cycles k+1..k+5; strobe low for k+2..k+4.
  - DONE in k+5; RECOV in k+6..k+7; IDLE in k+8.
  - Earliest next acceptance at edge k+8, so the back-to-back period is 8 cycles.
- DSACK register:
  - Set by SET_DSACK, cleared by CLR_DSACK.
  - SET_DSACK and CLR_DSACK in the same cycle: set wins.
  - Independent of the access FSM; reset clears it.
- BUSY: 1 in SETUP, STROBE, HOLD and RECOV, and 0 only in IDLE.

Test Plan:
- CPU read, defaults: SCSI_CS=1, RE=1 for 1 cycle at edge k -> _CSS low k+1..k+5, _IOR low k+2..k+4, RD_LATCH at k+4, DONE at k+5, BUSY low again at k+8, _IOW and _DACK stay high.
- DMA write, defaults, request held high continuously -> _DACK/_IOW pattern as above repeats every 8 cycles, RD_LATCH never pulses, _CSS stays high.
- Illegal and priority cases:
  - SCSI_CS=DACK=1, WE=1 -> only _CSS toggles, _DACK stays high.
  - RE=WE=1 with SCSI_CS=1 -> ERR pulse for 1 cycle, no strobes, BUSY=0.
- Parameter corners: SETUP_CYC=0, STROBE_CYC=1, RECOV_CYC=0 -> read accepted at k gives _CSS low k+1..k+2, _IOR low k+1 only, DONE at k+2, next acceptance at edge k+3.
- Reset mid-strobe: assert RST during the second STROBE cycle of a write -> next edge all strobes high, BUSY=0, no DONE; a new request 1 cycle after RST drops is accepted normally.
- DSACK register sequence: SET_DSACK pulse -> DSACK=1 next edge; SET_DSACK with CLR_DSACK together -> DSACK=1; CLR_DSACK alone -> DSACK=0 next edge; RST -> DSACK=0.

Source files
------------

// File: rtl/scsi_bus_strobe.sv
// scsi_bus_strobe: timing stage between the SCSI state-machine output decode
// and the WD33C93. Turns level requests into sequenced select and strobe
// pulses with setup, pulse, hold and recovery timing. It also returns DONE and
// RD_LATCH to the state machine and holds the CPU DSACK level.
//
// Ports:
//   CLK45            system clock, rising edge
//   RST              synchronous active-high reset
//   SCSI_CS, DACK    select requests (CPU register / DMA), active-high
//   RE, WE           access direction, exactly one must be set
//   SET_DSACK        set the DSACK level
//   CLR_DSACK        clear the DSACK level
//   _CSS, _DACK      WD33C93 select lines, active-low
//   _IOR, _IOW       read/write strobes, active-low
//   BUSY             access in progress (any state but IDLE)
//   DONE             one-cycle pulse in HOLD
//   RD_LATCH         one-cycle pulse on the last strobe cycle of a read
//   DSACK            registered DSACK level
//   ERR              one-cycle pulse on an illegal request
module scsi_bus_strobe #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned RECOV_CYC  = 2
) (
    input  logic CLK45,
    input  logic RST,
    input  logic SCSI_CS,
    input  logic DACK,
    input  logic RE,
    input  logic WE,
    input  logic SET_DSACK,
    input  logic CLR_DSACK,
    output logic _CSS,
    output logic _DACK,
    output logic _IOR,
    output logic _IOW,
    output logic BUSY,
    output logic DONE,
    output logic RD_LATCH,
    output logic DSACK,
    output logic ERR
);

    localparam int unsigned CNT_W = 4;

    // Counter load values: a phase of N cycles loads N-1 and exits at 0.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 32'd1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_CYC - 32'd1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RECOV  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_cs_q, sel_cs_d;
    logic             rd_q, rd_d;
    logic             css_n_q, css_n_d;
    logic             dack_n_q, dack_n_d;
    logic             ior_n_q, ior_n_d;
    logic             iow_n_q, iow_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_latch_q, rd_latch_d;
    logic             dsack_q, dsack_d;
    logic             err_q, err_d;
    logic             sel_active;

    // State and output registers.
    always_ff @(posedge CLK45) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_cs_q   <= 1'b0;
            rd_q       <= 1'b0;
            css_n_q    <= 1'b1;
            dack_n_q   <= 1'b1;
            ior_n_q    <= 1'b1;
            iow_n_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_latch_q <= 1'b0;
            dsack_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_cs_q   <= sel_cs_d;
            rd_q       <= rd_d;
            css_n_q    <= css_n_d;
            dack_n_q   <= dack_n_d;
            ior_n_q    <= ior_n_d;
            iow_n_q    <= iow_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_latch_q <= rd_latch_d;
            dsack_q    <= dsack_d;
            err_q      <= err_d;
        end
    end

    // Next state, plus outputs decoded from the next state so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_cs_d   = sel_cs_q;
        rd_d       = rd_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (SCSI_CS || DACK) begin
                    if (RE ^ WE) begin
                        // SCSI_CS has priority when both selects are present.
                        sel_cs_d = SCSI_CS;
                        rd_d     = RE;
                        if (SETUP_CYC != 32'd0) begin
                            state_d = SETUP;
                            cnt_d   = SETUP_LD;
                        end else begin
                            state_d = STROBE;
                            cnt_d   = STROBE_LD;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (RECOV_CYC != 32'd0) begin
                    state_d = RECOV;
                    cnt_d   = RECOV_LD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            RECOV: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        sel_active = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        css_n_d    = ~(sel_active & sel_cs_d);
        dack_n_d   = ~(sel_active & ~sel_cs_d);
        ior_n_d    = ~((state_d == STROBE) & rd_d);
        iow_n_d    = ~((state_d == STROBE) & ~rd_d);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == HOLD);
        rd_latch_d = (state_d == STROBE) && rd_d && (cnt_d == '0);

        // DSACK level: set has priority over clear.
        if (SET_DSACK) begin
            dsack_d = 1'b1;
        end else if (CLR_DSACK) begin
            dsack_d = 1'b0;
        end else begin
            dsack_d = dsack_q;
        end
    end

    assign _CSS     = css_n_q;
    assign _DACK    = dack_n_q;
    assign _IOR     = ior_n_q;
    assign _IOW     = iow_n_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RD_LATCH = rd_latch_q;
    assign DSACK    = dsack_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_scsi_bus_strobe.sv
// Testbench for scsi_bus_strobe: a default-parameter instance and a
// SETUP=0/STROBE=1/RECOV=0 instance share one stimulus stream. Each instance
// is checked every cycle against a timeline model. The model computes
// expected outputs from the cycle offset since acceptance.
module tb_scsi_bus_strobe;

    logic CLK45 = 1'b0;
    logic rst, cs, dack, re, we, set_ds, clr_ds;

    logic css0, dackn0, ior0, iow0, busy0, done0, rdl0, dsack0, err0;
    logic css1, dackn1, ior1, iow1, busy1, done1, rdl1, dsack1, err1;

    always #5 CLK45 = ~CLK45;

    scsi_bus_strobe #(.SETUP_CYC(1), .STROBE_CYC(3), .RECOV_CYC(2)) u_dut_def (
        .CLK45(CLK45), .RST(rst), .SCSI_CS(cs), .DACK(dack), .RE(re), .WE(we),
        .SET_DSACK(set_ds), .CLR_DSACK(clr_ds),
        ._CSS(css0), ._DACK(dackn0), ._IOR(ior0), ._IOW(iow0),
        .BUSY(busy0), .DONE(done0), .RD_LATCH(rdl0), .DSACK(dsack0), .ERR(err0)
    );

    scsi_bus_strobe #(.SETUP_CYC(0), .STROBE_CYC(1), .RECOV_CYC(0)) u_dut_min (
        .CLK45(CLK45), .RST(rst), .SCSI_CS(cs), .DACK(dack), .RE(re), .WE(we),
        .SET_DSACK(set_ds), .CLR_DSACK(clr_ds),
        ._CSS(css1), ._DACK(dackn1), ._IOR(ior1), ._IOW(iow1),
        .BUSY(busy1), .DONE(done1), .RD_LATCH(rdl1), .DSACK(dsack1), .ERR(err1)
    );

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    // Model state per instance.
    int p_s[2];
    int p_t[2];
    int p_r[2];
    bit m_active[2];
    int m_acc[2];
    bit m_cs[2];
    bit m_rd[2];
    bit m_err[2];
    bit m_dsack[2];

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %b expected %b", tag, edge_n, got, exp);
        end
    endtask

    // Model update at a rising edge from the inputs that were stable before it.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_active[d] = 1'b0;
                m_err[d]    = 1'b0;
                m_dsack[d]  = 1'b0;
            end else begin
                m_err[d] = 1'b0;
                if (set_ds) m_dsack[d] = 1'b1;
                else if (clr_ds) m_dsack[d] = 1'b0;
                // Idle in the cycle before this edge means a request can be taken.
                if (!m_active[d] || (edge_n - m_acc[d] >= p_s[d] + p_t[d] + p_r[d] + 2)) begin
                    if (cs || dack) begin
                        if (re ^ we) begin
                            m_active[d] = 1'b1;
                            m_acc[d]    = edge_n;
                            m_cs[d]     = cs;
                            m_rd[d]     = re;
                        end else begin
                            m_err[d] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_dut(input int d);
        int  t;
        int  s;
        int  st;
        int  r;
        bit  sel, stb, busy, done, rdl;
        logic [8:0] got;
        string pfx;
        s = p_s[d]; st = p_t[d]; r = p_r[d];
        t = edge_n - m_acc[d] + 1;
        sel = 0; stb = 0; busy = 0; done = 0; rdl = 0;
        if (m_active[d] && t >= 1 && t <= s + st + 1 + r) begin
            busy = 1;
            sel  = (t <= s + st + 1);
            stb  = (t >= s + 1) && (t <= s + st);
            rdl  = m_rd[d] && (t == s + st);
            done = (t == s + st + 1);
        end
        if (d == 0) begin
            got = {css0, dackn0, ior0, iow0, busy0, done0, rdl0, dsack0, err0};
            pfx = "def";
        end else begin
            got = {css1, dackn1, ior1, iow1, busy1, done1, rdl1, dsack1, err1};
            pfx = "min";
        end
        check_bit({pfx, "._CSS"},     got[8], !(sel && m_cs[d]));
        check_bit({pfx, "._DACK"},    got[7], !(sel && !m_cs[d]));
        check_bit({pfx, "._IOR"},     got[6], !(stb && m_rd[d]));
        check_bit({pfx, "._IOW"},     got[5], !(stb && !m_rd[d]));
        check_bit({pfx, ".BUSY"},     got[4], busy);
        check_bit({pfx, ".DONE"},     got[3], done);
        check_bit({pfx, ".RD_LATCH"}, got[2], rdl);
        check_bit({pfx, ".DSACK"},    got[1], m_dsack[d]);
        check_bit({pfx, ".ERR"},      got[0], m_err[d]);
    endtask

    task automatic step();
        @(posedge CLK45);
        edge_n++;
        model_edge();
        @(negedge CLK45);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic drive(input bit r, input bit c, input bit k, input bit rd,
                         input bit wr, input bit st, input bit cl);
        rst = r; cs = c; dack = k; re = rd; we = wr; set_ds = st; clr_ds = cl;
    endtask

    task automatic idle_steps(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        p_s[0] = 1; p_t[0] = 3; p_r[0] = 2;
        p_s[1] = 0; p_t[1] = 1; p_r[1] = 0;
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 0; m_acc[d] = 0; m_cs[d] = 0; m_rd[d] = 0;
            m_err[d] = 0; m_dsack[d] = 0;
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK45);
        step();
        step();

        // CPU read, single-cycle request.
        drive(0, 1, 0, 1, 0, 0, 0);
        step();
        idle_steps(9);

        // DMA write with the request held continuously.
        drive(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 24; i++) step();
        idle_steps(9);

        // Both selects: SCSI_CS wins.
        drive(0, 1, 1, 0, 1, 0, 0);
        step();
        idle_steps(9);

        // Illegal direction combinations.
        drive(0, 1, 0, 1, 1, 0, 0);
        step();
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        idle_steps(3);

        // Reset during the second strobe cycle of a write, then a new request.
        drive(0, 1, 0, 0, 1, 0, 0);
        step();
        idle_steps(2);
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        idle_steps(1);
        drive(0, 1, 0, 1, 0, 0, 0);
        step();
        idle_steps(9);

        // DSACK set / set+clear / clear / reset.
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        idle_steps(2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0));
            step();
        end
        idle_steps(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
